// File: rtl/design_switcher.sv
// -----------------------------------------------------------------------------
// design_switcher
//
// Connects one of N_DESIGNS user designs to a shared GPIO pad bus.
//
// A raw select code from the logic analyzer passes through a stability filter.
// Every change of the connected design goes through an isolation window
// (DRAIN). During DRAIN every design is held in reset and the pads are tri-stated.
//
// Ports
//   clk           : single clock for all logic
//   nrst          : synchronous active-low reset
//   design_select : raw select; 0 = none, k in 1..N_DESIGNS = design k-1,
//                   values above N_DESIGNS are treated as 0
//   gpio_in       : pad inputs
//   gpio_out      : pad outputs (slice of the active design, else 0)
//   gpio_oeb      : pad output enables, active-low (all 1s unless ACTIVE)
//   des_gpio_in   : per-design input slices; only the active slice is non-zero
//   des_gpio_out  : per-design output slices
//   des_gpio_oeb  : per-design output-enable slices
//   des_nrst      : per-design active-low resets; at most one bit high
//   active_sel    : select code currently connected
//   switching     : high while the isolation window is open
// -----------------------------------------------------------------------------
module design_switcher #(
  parameter int N_DESIGNS  = 15,
  parameter int GPIO_W     = 34,
  parameter int SEL_W      = 4,
  parameter int STABLE_CYC = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [SEL_W-1:0]              design_select,
  input  logic [GPIO_W-1:0]             gpio_in,
  output logic [GPIO_W-1:0]             gpio_out,
  output logic [GPIO_W-1:0]             gpio_oeb,
  output logic [N_DESIGNS*GPIO_W-1:0]   des_gpio_in,
  input  logic [N_DESIGNS*GPIO_W-1:0]   des_gpio_out,
  input  logic [N_DESIGNS*GPIO_W-1:0]   des_gpio_oeb,
  output logic [N_DESIGNS-1:0]          des_nrst,
  output logic [SEL_W-1:0]              active_sel,
  output logic                          switching
);

  localparam int FCNT_W = $clog2(STABLE_CYC + 1);
  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX  = FCNT_W'(STABLE_CYC - 1);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  logic [SEL_W-1:0]  sel_clean_s;
  logic [SEL_W-1:0]  cand_r, cand_nxt_s;
  logic [FCNT_W-1:0] fcnt_r, fcnt_nxt_s;
  logic [SEL_W-1:0]  req_sel_r, req_sel_nxt_s;
  state_t            state_r, state_nxt_s;
  logic [SEL_W-1:0]  active_sel_r, active_sel_nxt_s;
  logic [SCNT_W-1:0] settle_r, settle_nxt_s;
  // Request value the current DRAIN window is heading for. A change of the
  // request restarts the window, so DRAIN is never shortened.
  logic [SEL_W-1:0]  drain_tgt_r, drain_tgt_nxt_s;

  // Map out-of-range select codes onto "no design".
  always_comb begin
    sel_clean_s = design_select;
    if (design_select > SEL_W'(N_DESIGNS)) begin
      sel_clean_s = {SEL_W{1'b0}};
    end else begin
      sel_clean_s = design_select;
    end
  end

  // Stability filter. The next count is used, so a select held for
  // STABLE_CYC samples becomes the request on the last of those edges.
  always_comb begin
    cand_nxt_s    = cand_r;
    fcnt_nxt_s    = fcnt_r;
    req_sel_nxt_s = req_sel_r;
    if (sel_clean_s != cand_r) begin
      cand_nxt_s = sel_clean_s;
      fcnt_nxt_s = {FCNT_W{1'b0}};
    end else if (fcnt_r != FCNT_MAX) begin
      fcnt_nxt_s = fcnt_r + FCNT_W'(1);
    end else begin
      fcnt_nxt_s = fcnt_r;
    end
    if (fcnt_nxt_s == FCNT_MAX) begin
      req_sel_nxt_s = cand_nxt_s;
    end else begin
      req_sel_nxt_s = req_sel_r;
    end
  end

  // Switch FSM: next-state logic, settle counter and active select update.
  always_comb begin
    state_nxt_s      = state_r;
    active_sel_nxt_s = active_sel_r;
    settle_nxt_s     = settle_r;
    drain_tgt_nxt_s  = drain_tgt_r;
    case (state_r)
      ST_OFF, ST_ACTIVE: begin
        if (req_sel_r != active_sel_r) begin
          state_nxt_s     = ST_DRAIN;
          settle_nxt_s    = SCNT_LOAD;
          drain_tgt_nxt_s = req_sel_r;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DRAIN: begin
        if (req_sel_r != drain_tgt_r) begin
          settle_nxt_s    = SCNT_LOAD;
          drain_tgt_nxt_s = req_sel_r;
        end else if (settle_r == {SCNT_W{1'b0}}) begin
          active_sel_nxt_s = req_sel_r;
          if (req_sel_r == {SEL_W{1'b0}}) begin
            state_nxt_s = ST_OFF;
          end else begin
            state_nxt_s = ST_ACTIVE;
          end
        end else begin
          settle_nxt_s = settle_r - SCNT_W'(1);
        end
      end
      default: begin
        state_nxt_s      = ST_OFF;
        active_sel_nxt_s = {SEL_W{1'b0}};
        settle_nxt_s     = {SCNT_W{1'b0}};
        drain_tgt_nxt_s  = {SEL_W{1'b0}};
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cand_r       <= {SEL_W{1'b0}};
      fcnt_r       <= {FCNT_W{1'b0}};
      req_sel_r    <= {SEL_W{1'b0}};
      state_r      <= ST_OFF;
      active_sel_r <= {SEL_W{1'b0}};
      settle_r     <= {SCNT_W{1'b0}};
      drain_tgt_r  <= {SEL_W{1'b0}};
    end else begin
      cand_r       <= cand_nxt_s;
      fcnt_r       <= fcnt_nxt_s;
      req_sel_r    <= req_sel_nxt_s;
      state_r      <= state_nxt_s;
      active_sel_r <= active_sel_nxt_s;
      settle_r     <= settle_nxt_s;
      drain_tgt_r  <= drain_tgt_nxt_s;
    end
  end

  // Pad and design routing. Only ACTIVE connects anything. The selection
  // depends on registered state only, so pads never see a non-active oeb.
  always_comb begin
    gpio_out    = {GPIO_W{1'b0}};
    gpio_oeb    = {GPIO_W{1'b1}};
    des_gpio_in = {(N_DESIGNS*GPIO_W){1'b0}};
    des_nrst    = {N_DESIGNS{1'b0}};
    if (state_r == ST_ACTIVE) begin
      for (int i = 0; i < N_DESIGNS; i++) begin
        if (active_sel_r == SEL_W'(i + 1)) begin
          des_nrst[i]                       = 1'b1;
          gpio_out                          = des_gpio_out[i*GPIO_W +: GPIO_W];
          gpio_oeb                          = des_gpio_oeb[i*GPIO_W +: GPIO_W];
          des_gpio_in[i*GPIO_W +: GPIO_W]   = gpio_in;
        end else begin
          des_nrst[i] = 1'b0;
        end
      end
    end else begin
      des_nrst = {N_DESIGNS{1'b0}};
    end
  end

  assign active_sel = active_sel_r;
  assign switching  = (state_r == ST_DRAIN);

endmodule

// File: tb/tb_design_switcher.sv
// Bench for design_switcher: instance A uses the default parameters.
// Instance B is a scaled-down variant (3 designs, 8-bit GPIO, 1-cycle settle).
// Both are checked every cycle against a behavioural model.
module tb_design_switcher;

  localparam int A_N = 15, A_W = 34, A_S = 4;
  localparam int B_N = 3,  B_W = 8,  B_S = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;

  logic [A_S-1:0]     sel_a = '0;
  logic [A_W-1:0]     gin_a = '0, gout_a, goeb_a;
  logic [A_N*A_W-1:0] dgi_a, dgo_a = '0, doeb_a = '0;
  logic [A_N-1:0]     dnrst_a;
  logic [A_S-1:0]     act_a;
  logic               sw_a;

  logic [B_S-1:0]     sel_b = '0;
  logic [B_W-1:0]     gin_b = '0, gout_b, goeb_b;
  logic [B_N*B_W-1:0] dgi_b, dgo_b = '0, doeb_b = '0;
  logic [B_N-1:0]     dnrst_b;
  logic [B_S-1:0]     act_b;
  logic               sw_b;

  int vectors = 0;
  int miscompares = 0;
  int drain_cnt_a = 0;
  bit d6_seen = 1'b0;

  // model state, index 0 = instance A, 1 = instance B
  int p_n[2]    = '{15, 3};
  int p_w[2]    = '{34, 8};
  int p_stab[2] = '{4, 4};
  int p_set[2]  = '{8, 1};
  int m_mode[2];   // 0 none connected, 1 connected, 2 isolating
  int m_act[2];
  int m_req[2];
  int m_tgt[2];
  int m_left[2];   // isolation cycles still to go
  int hist[2][16]; // recent cleaned select samples, newest first

  always #5 clk = ~clk;

  design_switcher #(.N_DESIGNS(A_N), .GPIO_W(A_W), .SEL_W(A_S),
                    .STABLE_CYC(4), .SETTLE_CYC(8)) dut_a (
    .clk(clk), .nrst(nrst), .design_select(sel_a), .gpio_in(gin_a),
    .gpio_out(gout_a), .gpio_oeb(goeb_a), .des_gpio_in(dgi_a),
    .des_gpio_out(dgo_a), .des_gpio_oeb(doeb_a), .des_nrst(dnrst_a),
    .active_sel(act_a), .switching(sw_a));

  design_switcher #(.N_DESIGNS(B_N), .GPIO_W(B_W), .SEL_W(B_S),
                    .STABLE_CYC(4), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .nrst(nrst), .design_select(sel_b), .gpio_in(gin_b),
    .gpio_out(gout_b), .gpio_oeb(goeb_b), .des_gpio_in(dgi_b),
    .des_gpio_out(dgo_b), .des_gpio_oeb(doeb_b), .des_nrst(dnrst_b),
    .active_sel(act_b), .switching(sw_b));

  // Model: a select becomes the request once its last STABLE_CYC samples agree.
  // Any request differing from the connected one opens an isolation window of
  // SETTLE_CYC cycles. The window restarts whenever the request moves.
  task automatic model_step(input int d, input logic rst_n, input int raw);
    int s;
    bit same;
    if (!rst_n) begin
      m_mode[d] = 0; m_act[d] = 0; m_req[d] = 0; m_tgt[d] = 0; m_left[d] = 0;
      for (int i = 0; i < 16; i++) hist[d][i] = -1;
      hist[d][0] = 0;
      return;
    end
    s = (raw > p_n[d]) ? 0 : raw;
    if (m_mode[d] == 2) begin
      if (m_req[d] != m_tgt[d]) begin
        m_tgt[d] = m_req[d]; m_left[d] = p_set[d];
      end else if (m_left[d] == 1) begin
        m_act[d] = m_req[d];
        m_mode[d] = (m_req[d] == 0) ? 0 : 1;
      end else begin
        m_left[d] = m_left[d] - 1;
      end
    end else if (m_req[d] != m_act[d]) begin
      m_mode[d] = 2; m_left[d] = p_set[d]; m_tgt[d] = m_req[d];
    end
    for (int i = 15; i > 0; i--) hist[d][i] = hist[d][i-1];
    hist[d][0] = s;
    same = 1'b1;
    for (int i = 0; i < p_stab[d]; i++) if (hist[d][i] != s) same = 1'b0;
    if (same) m_req[d] = s;
  endtask

  always @(posedge clk) begin
    model_step(0, nrst, int'(sel_a));
    model_step(1, nrst, int'(sel_b));
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int d, input logic [3:0] act_o, input logic sw_o,
                           input logic [14:0] dn_o, input logic [63:0] go_o,
                           input logic [63:0] goe_o, input logic [511:0] dgi_o,
                           input logic [511:0] dgo, input logic [511:0] doeb,
                           input logic [63:0] gin);
    int w, k;
    logic [63:0] mask, e_go, e_goe;
    logic [511:0] t_o, t_e, e_dgi;
    logic [14:0] e_dn;
    string p;
    w = p_w[d];
    k = m_act[d];
    p = (d == 0) ? "A" : "B";
    mask = (64'd1 << w) - 64'd1;
    e_go = 64'd0; e_goe = mask; e_dgi = 512'd0; e_dn = 15'd0;
    if (m_mode[d] == 1) begin
      t_o = dgo >> ((k-1)*w);
      t_e = doeb >> ((k-1)*w);
      e_go = t_o[63:0] & mask;
      e_goe = t_e[63:0] & mask;
      e_dgi = 512'(gin & mask) << ((k-1)*w);
      e_dn = 15'd1 << (k-1);
    end
    chk({p, ".active_sel"}, 512'(act_o), 512'(k));
    chk({p, ".switching"}, 512'(sw_o), 512'(m_mode[d] == 2));
    chk({p, ".des_nrst"}, 512'(dn_o), 512'(e_dn));
    chk({p, ".onehot"}, 512'($onehot0(dn_o)), 512'(1));
    chk({p, ".gpio_out"}, 512'(go_o), 512'(e_go));
    chk({p, ".gpio_oeb"}, 512'(goe_o), 512'(e_goe));
    chk({p, ".des_gpio_in"}, dgi_o, e_dgi);
  endtask

  task automatic step(input int n);
    logic [511:0] r1, r2;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        r1[i*32 +: 32] = $urandom;
        r2[i*32 +: 32] = $urandom;
      end
      dgo_a = r1[A_N*A_W-1:0]; doeb_a = r2[A_N*A_W-1:0];
      dgo_b = r1[B_N*B_W-1:0]; doeb_b = r2[B_N*B_W-1:0];
      gin_a = {2'($urandom), 32'($urandom)};
      gin_b = 8'($urandom);
      #1;
      if (sw_a) drain_cnt_a++;
      if (dnrst_a[6]) d6_seen = 1'b1;
      check_dut(0, act_a, sw_a, dnrst_a, 64'(gout_a), 64'(goeb_a), 512'(dgi_a),
                512'(dgo_a), 512'(doeb_a), 64'(gin_a));
      check_dut(1, 4'(act_b), sw_b, 15'(dnrst_b), 64'(gout_b), 64'(goeb_b), 512'(dgi_b),
                512'(dgo_b), 512'(doeb_b), 64'(gin_b));
    end
  endtask

  initial begin
    // reset
    nrst = 1'b0; sel_a = 4'd0; sel_b = 3'd0;
    step(3);
    chk("reset.sw", 512'(sw_a), 512'(0));
    chk("reset.oeb", 512'(goeb_a), 512'(34'h3_FFFF_FFFF));
    chk("reset.act", 512'(act_a), 512'(0));
    nrst = 1'b1;
    step(1);

    // glitch shorter than the filter window
    drain_cnt_a = 0;
    sel_a = 4'd5; step(3);
    sel_a = 4'd0; step(6);
    chk("glitch.drains", 512'(drain_cnt_a), 512'(0));
    chk("glitch.oeb", 512'(goeb_a), 512'(34'h3_FFFF_FFFF));

    // basic select of code 3 (A) and code 2 (B)
    sel_a = 4'd3; sel_b = 3'd2;
    step(4); chk("basic.sw_before", 512'(sw_a), 512'(0));
    step(1); chk("basic.sw_rise", 512'(sw_a), 512'(1));
    step(7); chk("basic.sw_hold", 512'(sw_a), 512'(1));
    step(1); chk("basic.sw_fall", 512'(sw_a), 512'(0));
    chk("basic.act", 512'(act_a), 512'(3));
    chk("basic.nrst", 512'(dnrst_a), 512'(15'h0004));
    chk("basic.gout", 512'(gout_a), 512'(dgo_a[2*A_W +: A_W]));
    chk("basic.goeb", 512'(goeb_a), 512'(doeb_a[2*A_W +: A_W]));
    chk("basicB.act", 512'(act_b), 512'(2));
    chk("basicB.nrst", 512'(dnrst_b), 512'(3'b010));

    // re-target: 7 accepted, then 9 accepted three cycles into the window
    drain_cnt_a = 0; d6_seen = 1'b0;
    sel_a = 4'd7; step(4);
    sel_a = 4'd9; step(20);
    chk("retarget.drain_len", 512'(drain_cnt_a), 512'(12));
    chk("retarget.d6", 512'(d6_seen), 512'(0));
    chk("retarget.act", 512'(act_a), 512'(9));
    chk("retarget.nrst", 512'(dnrst_a), 512'(15'h0100));

    // out-of-range select on the small instance
    sel_b = 3'd6; step(6);
    chk("oor.act", 512'(act_b), 512'(0));
    chk("oor.nrst", 512'(dnrst_b), 512'(0));

    // reset in the fifth isolation cycle
    sel_a = 4'd4; step(5);
    chk("rstmid.sw_in", 512'(sw_a), 512'(1));
    step(4);
    nrst = 1'b0; step(1);
    chk("rstmid.sw", 512'(sw_a), 512'(0));
    chk("rstmid.oeb", 512'(goeb_a), 512'(34'h3_FFFF_FFFF));
    chk("rstmid.act", 512'(act_a), 512'(0));
    nrst = 1'b1;

    // random selects with random hold times and occasional resets
    for (int k = 0; k < 80; k++) begin
      sel_a = 4'($urandom_range(0, 15));
      sel_b = 3'($urandom_range(0, 7));
      nrst = ($urandom_range(0, 24) != 0);
      step(1);
      nrst = 1'b1;
      step($urandom_range(1, 12));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
